// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                           |
// | Description : Two-requester arbiter for one port of dual_port_byte_mem.  |
// |               Grants at most one request per cycle and forwards it to   |
// |               the memory port with no added latency. A fixed-latency    |
// |               tag pipeline routes each read response back to the        |
// |               requester that issued it, and a sticky error flag reports |
// |               unexpected or missing read responses.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Configuration macro:                                                     |
// |   MEM_ARB_RR_EN  defined   -> two-way round-robin arbitration           |
// |                  undefined -> fixed priority, requester 0 wins          |
// +--------------------------------------------------------------------------+
// | Ports:                                                                   |
// |   clk, rst_n            clock, synchronous active-low reset              |
// |   rN_valid/rN_ready     request handshake, requester N (0 = core,        |
// |                         1 = debug loader / DMA)                          |
// |   rN_addr/wdata/wstrb   request fields; wstrb == 0 means read            |
// |   rN_rdata/rN_rvalid    read response (rdata mirrors m_rdata)            |
// |   m_valid/addr/wdata/   memory request, granted requester's fields or 0 |
// |   m_wstrb                                                                |
// |   m_rdata/m_rvalid      memory read response                             |
// |   protocol_err          sticky: unexpected or missing read response      |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  r0_valid,
   output logic                  r0_ready,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [31:0]           r0_wdata,
   input  logic [3:0]            r0_wstrb,
   output logic [31:0]           r0_rdata,
   output logic                  r0_rvalid,
   input  logic                  r1_valid,
   output logic                  r1_ready,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [31:0]           r1_wdata,
   input  logic [3:0]            r1_wstrb,
   output logic [31:0]           r1_rdata,
   output logic                  r1_rvalid,
   output logic                  m_valid,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [31:0]           m_wdata,
   output logic [3:0]            m_wstrb,
   input  logic [31:0]           m_rdata,
   input  logic                  m_rvalid,
   output logic                  protocol_err
);

   localparam int c_cnt_w = $clog2(RD_LATENCY + 1);

   logic w_gnt0;
   logic w_gnt1;

   // ---------------------------------------------------------------------
   // Arbitration. Grants are forced low while in reset so no request can be
   // accepted on a reset edge.
   // ---------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
   // Requester of the last accepted request; on contention the other wins.
   // Resets to 1 so that requester 0 is favoured first.
   logic last_q;
   logic last_d;

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (rst_n) begin
         if (r0_valid && r1_valid) begin
            w_gnt0 = last_q;
            w_gnt1 = ~last_q;
         end else begin
            w_gnt0 = r0_valid;
            w_gnt1 = r1_valid;
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (w_gnt0) begin
         last_d = 1'b0;
      end else if (w_gnt1) begin
         last_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      w_gnt0 = rst_n & r0_valid;
      w_gnt1 = rst_n & r1_valid & ~r0_valid;
   end
`endif

   assign r0_ready = w_gnt0;
   assign r1_ready = w_gnt1;

   // ---------------------------------------------------------------------
   // Request forwarding: granted requester's fields, all zero when idle.
   // ---------------------------------------------------------------------
   always_comb begin
      m_valid = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_wstrb = '0;
      if (w_gnt0) begin
         m_valid = 1'b1;
         m_addr  = r0_addr;
         m_wdata = r0_wdata;
         m_wstrb = r0_wstrb;
      end else if (w_gnt1) begin
         m_valid = 1'b1;
         m_addr  = r1_addr;
         m_wdata = r1_wdata;
         m_wstrb = r1_wstrb;
      end
   end

   // ---------------------------------------------------------------------
   // Tag pipeline: one stage per cycle of memory read latency. The last
   // stage lines up with the cycle in which the memory presents read data.
   // ---------------------------------------------------------------------
   logic [RD_LATENCY-1:0] tag_vld_q;
   logic [RD_LATENCY-1:0] tag_id_q;
   logic                  w_push_vld;
   logic                  w_out_vld;
   logic                  w_out_id;

   assign w_push_vld = m_valid & (m_wstrb == 4'b0000);
   assign w_out_vld  = tag_vld_q[RD_LATENCY-1];
   assign w_out_id   = tag_id_q[RD_LATENCY-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         tag_vld_q[0] <= w_push_vld;
         tag_id_q[0]  <= w_gnt1;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_id_q[i]  <= tag_id_q[i-1];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Post-reset drain window: the memory may still return data for reads
   // issued before reset. Those responses are dropped and not flagged.
   // ---------------------------------------------------------------------
   logic [c_cnt_w-1:0] drain_q;
   logic [c_cnt_w-1:0] drain_d;
   logic               w_draining;

   assign w_draining = (drain_q != '0);

   always_comb begin
      drain_d = drain_q;
      if (w_draining) begin
         drain_d = drain_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drain_q <= c_cnt_w'(RD_LATENCY);
      end else begin
         drain_q <= drain_d;
      end
   end

   // ---------------------------------------------------------------------
   // Response routing and error detection
   // ---------------------------------------------------------------------
   logic w_resp_ok;

   assign w_resp_ok = m_rvalid & w_out_vld & ~w_draining;
   assign r0_rvalid = w_resp_ok & ~w_out_id;
   assign r1_rvalid = w_resp_ok &  w_out_id;
   assign r0_rdata  = m_rdata;
   assign r1_rdata  = m_rdata;

   logic err_q;
   logic err_d;

   // A response without a tag, or a tag without a response, are both errors.
   assign err_d = err_q | (~w_draining & (m_rvalid ^ w_out_vld));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign protocol_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                        |
// | Description : Directed self-checking bench for mem_port_arbiter with a   |
// |               small behavioural memory of read latency RD_LATENCY.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

   localparam int ADDR_WIDTH = 16;
   localparam int RD_LATENCY = 2;

   logic                  clk;
   logic                  rst_n;
   logic                  r0_valid, r1_valid;
   logic                  r0_ready, r1_ready;
   logic [ADDR_WIDTH-1:0] r0_addr, r1_addr;
   logic [31:0]           r0_wdata, r1_wdata;
   logic [3:0]            r0_wstrb, r1_wstrb;
   logic [31:0]           r0_rdata, r1_rdata;
   logic                  r0_rvalid, r1_rvalid;
   logic                  m_valid;
   logic [ADDR_WIDTH-1:0] m_addr;
   logic [31:0]           m_wdata;
   logic [3:0]            m_wstrb;
   logic [31:0]           m_rdata;
   logic                  m_rvalid;
   logic                  protocol_err;

   int n_checks = 0;
   int n_pass   = 0;

   mem_port_arbiter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .r0_valid     (r0_valid),
      .r0_ready     (r0_ready),
      .r0_addr      (r0_addr),
      .r0_wdata     (r0_wdata),
      .r0_wstrb     (r0_wstrb),
      .r0_rdata     (r0_rdata),
      .r0_rvalid    (r0_rvalid),
      .r1_valid     (r1_valid),
      .r1_ready     (r1_ready),
      .r1_addr      (r1_addr),
      .r1_wdata     (r1_wdata),
      .r1_wstrb     (r1_wstrb),
      .r1_rdata     (r1_rdata),
      .r1_rvalid    (r1_rvalid),
      .m_valid      (m_valid),
      .m_addr       (m_addr),
      .m_wdata      (m_wdata),
      .m_wstrb      (m_wstrb),
      .m_rdata      (m_rdata),
      .m_rvalid     (m_rvalid),
      .protocol_err (protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Behavioural memory: a read sampled at edge E is presented during the
   // cycle ending at edge E+RD_LATENCY. Not reset by rst_n, so a read in
   // flight across an arbiter reset still returns.
   // ---------------------------------------------------------------------
   logic [31:0] mem [0:255];
   logic        rd_vld [0:RD_LATENCY-1];
   logic [31:0] rd_dat [0:RD_LATENCY-1];
   logic        inject;    // force a stray m_rvalid
   logic        suppress;  // swallow a real m_rvalid

   assign m_rvalid = (rd_vld[RD_LATENCY-1] & ~suppress) | inject;
   assign m_rdata  = rd_dat[RD_LATENCY-1];

   always @(posedge clk) begin
      if (m_valid && m_wstrb != 4'b0000) begin
         for (int b = 0; b < 4; b++) begin
            if (m_wstrb[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
         end
      end
      rd_vld[0] <= m_valid && (m_wstrb == 4'b0000);
      rd_dat[0] <= mem[m_addr[9:2]];
      for (int s = 1; s < RD_LATENCY; s++) begin
         rd_vld[s] <= rd_vld[s-1];
         rd_dat[s] <= rd_dat[s-1];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      r0_valid = 1'b0; r0_addr = '0; r0_wdata = '0; r0_wstrb = '0;
      r1_valid = 1'b0; r1_addr = '0; r1_wdata = '0; r1_wstrb = '0;
   endtask

   // Reset, then wait out the drain window.
   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < RD_LATENCY + 1; i++) tick();
   endtask

   // Expected grant per cycle in the contention test and the data each
   // requester's read returns.
`ifdef MEM_ARB_RR_EN
   logic [3:0] exp_gnt = 4'b1010;   // bit k = requester granted in cycle k
   logic [3:0] both_on = 4'b1111;   // r0 held valid in cycles 0..3
`else
   logic [3:0] exp_gnt = 4'b1000;
   logic [3:0] both_on = 4'b0111;   // r0 drops in cycle 3
`endif

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      for (int s = 0; s < RD_LATENCY; s++) begin
         rd_vld[s] = 1'b0;
         rd_dat[s] = 32'h0;
      end
      mem[8'h04] = 32'hDEADBEEF;   // 0x0010
      mem[8'h10] = 32'hA0A0A0A0;   // 0x0040
      mem[8'h20] = 32'hB1B1B1B1;   // 0x0080
      inject   = 1'b0;
      suppress = 1'b0;
      idle_inputs();

      // ---- reset state, requests held valid during reset ----
      rst_n    = 1'b0;
      r0_valid = 1'b1;
      r1_valid = 1'b1;
      tick(); tick(); tick();
      check("rst_r0_ready", {31'b0, r0_ready}, 32'd0);
      check("rst_r1_ready", {31'b0, r1_ready}, 32'd0);
      check("rst_m_valid", {31'b0, m_valid}, 32'd0);
      check("rst_rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
      check("rst_err", {31'b0, protocol_err}, 32'd0);
      idle_inputs();
      rst_n = 1'b1;
      for (int i = 0; i < RD_LATENCY + 1; i++) tick();
      check("idle_m_addr", {16'b0, m_addr}, 32'd0);

      // ---- single read by r0 ----
      r0_valid = 1'b1; r0_addr = 16'h0010;
      #1;
      check("rd_r0_ready", {31'b0, r0_ready}, 32'd1);
      check("rd_m_addr", {m_valid, 15'b0, m_addr}, 32'h8000_0010);
      tick();                                   // accept edge E
      idle_inputs();
      #1;
      check("rd_idle_m", {m_valid, m_wstrb, 11'b0, m_addr}, 32'd0);
      check("rd_early", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
      tick();                                   // E+1: data visible
      check("rd_rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'd1);
      check("rd_rdata", r0_rdata, 32'hDEADBEEF);
      tick();
      check("rd_after", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
      check("rd_err", {31'b0, protocol_err}, 32'd0);

      // ---- contention: grant order and response routing ----
      do_reset();
      for (int k = 0; k < 6; k++) begin
         idle_inputs();
         if (k < 4) begin
            r0_valid = both_on[k]; r0_addr = 16'h0040;
            r1_valid = 1'b1;       r1_addr = 16'h0080;
         end
         #1;
         if (k < 4) begin
            check($sformatf("arb_ready_c%0d", k), {30'b0, r1_ready, r0_ready},
                  exp_gnt[k] ? 32'd2 : 32'd1);
         end
         if (k >= 2) begin
            check($sformatf("arb_rvalid_c%0d", k), {30'b0, r1_rvalid, r0_rvalid},
                  exp_gnt[k-2] ? 32'd2 : 32'd1);
            check($sformatf("arb_rdata_c%0d", k), r0_rdata,
                  exp_gnt[k-2] ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
         end
         tick();
      end
      check("arb_err", {31'b0, protocol_err}, 32'd0);

      // ---- r1 write then r0 read of the same word ----
      r1_valid = 1'b1; r1_addr = 16'h0020; r1_wdata = 32'h12345678; r1_wstrb = 4'hF;
      #1;
      check("wr_r1_ready", {31'b0, r1_ready}, 32'd1);
      check("wr_m_wdata", m_wdata, 32'h12345678);
      check("wr_m_wstrb", {28'b0, m_wstrb}, 32'hF);
      tick();
      idle_inputs();
      r0_valid = 1'b1; r0_addr = 16'h0020;
      tick();
      idle_inputs();
      #1;
      check("wr_no_resp", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
      tick();
      check("wr_rd_rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'd1);
      check("wr_rd_rdata", r0_rdata, 32'h12345678);
      tick();
      check("wr_err", {31'b0, protocol_err}, 32'd0);

      // ---- reset while a read is in flight ----
      r0_valid = 1'b1; r0_addr = 16'h0010;
      tick();                                   // accept edge E
      idle_inputs();
      rst_n = 1'b0;
      tick();                                   // reset sampled at E+1
      rst_n = 1'b1;
      #1;
      check("mid_rst_rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
      tick();
      check("mid_rst_rvalid2", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
      tick(); tick();
      check("mid_rst_err", {31'b0, protocol_err}, 32'd0);

      // ---- stray m_rvalid after the drain window ----
      inject = 1'b1;
      #1;
      check("inj_rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
      check("inj_err_pre", {31'b0, protocol_err}, 32'd0);
      tick();
      inject = 1'b0;
      check("inj_err_set", {31'b0, protocol_err}, 32'd1);
      tick(); tick(); tick();
      check("inj_err_sticky", {31'b0, protocol_err}, 32'd1);
      do_reset();
      check("inj_err_clr", {31'b0, protocol_err}, 32'd0);

      // ---- read whose response never arrives ----
      r1_valid = 1'b1; r1_addr = 16'h0080;
      tick();
      idle_inputs();
      tick();
      suppress = 1'b1;
      #1;
      check("miss_rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
      tick();
      suppress = 1'b0;
      check("miss_err", {31'b0, protocol_err}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
